gf_sram_port_ctrl: RTL and testbench

GF_SRAM_PORT_CTRL -- requirements
Module: gf_sram_port_ctrl

---
 rtl/gf_sram_port_ctrl.sv | 117 +++++++++++
 tb/tb_gf_sram_port_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gf_sram_port_ctrl.sv
// Fabric-side SRAM port controller: holds the macro idle until configured, optionally zeroes it, then passes user accesses through.
// Optional power-up clear sweep is enabled by defining GF_SRAM_PORT_CTRL_CLEAR_EN.
module gf_sram_port_ctrl #(
    parameter int WIDTH     = 8,
    parameter int ADDR_BITS = 9
) (
    input  logic                 UserCLK,
    input  logic                 RST,
    input  logic                 CONFIGURED_top,
    input  logic                 CEN,
    input  logic                 GWEN,
    input  logic [WIDTH-1:0]     WEN,
    input  logic [ADDR_BITS-1:0] A,
    input  logic [WIDTH-1:0]     D,
    output logic [WIDTH-1:0]     Q,
    output logic                 Q_VALID,
    output logic                 BUSY,
    output logic                 CEN_SRAM,
    output logic                 GWEN_SRAM,
    output logic [WIDTH-1:0]     WEN_SRAM,
    output logic [WIDTH-1:0]     D_SRAM,
    output logic [ADDR_BITS-1:0] A_SRAM,
    input  logic [WIDTH-1:0]     Q_SRAM,
    output logic                 CLK_SRAM
);

`ifdef GF_SRAM_PORT_CTRL_CLEAR_EN
    typedef enum logic [1:0] {UNCONF, CLEAR, READY} state_t;
    logic [ADDR_BITS-1:0] count_q;
`else
    typedef enum logic [1:0] {UNCONF, READY} state_t;
`endif

    state_t           state_q;
    logic             rdPending_q;
    logic [WIDTH-1:0] qHold_q;
    logic             userActive;
    logic             readAccept;

    assign CLK_SRAM   = UserCLK;
    assign userActive = (state_q == READY) && CONFIGURED_top && !RST;
    assign readAccept = userActive && !CEN && GWEN;
    assign BUSY       = !userActive;
    assign Q_VALID    = rdPending_q && !RST;
    assign Q          = RST ? '0 : (rdPending_q ? Q_SRAM : qHold_q);

    // Dropping CONFIGURED_top or holding reset parks the macro immediately, not one edge later.
    always_comb begin
        CEN_SRAM  = 1'b1;
        GWEN_SRAM = 1'b1;
        WEN_SRAM  = '1;
        A_SRAM    = '0;
        D_SRAM    = '0;
        if (!RST && CONFIGURED_top) begin
            if (state_q == READY) begin
                CEN_SRAM  = CEN;
                GWEN_SRAM = GWEN;
                WEN_SRAM  = WEN;
                A_SRAM    = A;
                D_SRAM    = D;
            end
`ifdef GF_SRAM_PORT_CTRL_CLEAR_EN
            else if (state_q == CLEAR) begin
                CEN_SRAM  = 1'b0;
                GWEN_SRAM = 1'b0;
                WEN_SRAM  = '0;
                A_SRAM    = count_q;
            end
`endif
        end
    end

    always_ff @(posedge UserCLK) begin
        if (RST) begin
            state_q     <= UNCONF;
            rdPending_q <= 1'b0;
            qHold_q     <= '0;
`ifdef GF_SRAM_PORT_CTRL_CLEAR_EN
            count_q     <= '0;
`endif
        end else begin
            rdPending_q <= readAccept;
            if (rdPending_q) begin
                qHold_q <= Q_SRAM;
            end
            if (!CONFIGURED_top) begin
                state_q <= UNCONF;
`ifdef GF_SRAM_PORT_CTRL_CLEAR_EN
                count_q <= '0;
`endif
            end else begin
                case (state_q)
                    UNCONF: begin
`ifdef GF_SRAM_PORT_CTRL_CLEAR_EN
                        state_q <= CLEAR;
                        count_q <= '0;
`else
                        state_q <= READY;
`endif
                    end
`ifdef GF_SRAM_PORT_CTRL_CLEAR_EN
                    // The last address is written in the cycle the counter reads all-ones.
                    CLEAR: begin
                        count_q <= count_q + 1'b1;
                        if (count_q == '1) begin
                            state_q <= READY;
                        end
                    end
`endif
                    READY:   state_q <= READY;
                    default: state_q <= UNCONF;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gf_sram_port_ctrl.sv
// Directed bench for gf_sram_port_ctrl with a behavioural 16x8 SRAM macro model on the SRAM side.
// Expectations follow GF_SRAM_PORT_CTRL_CLEAR_EN when it is defined for the build.
module tb_gf_sram_port_ctrl;

    logic       UserCLK;
    logic       RST;
    logic       CONFIGURED_top;
    logic       CEN;
    logic       GWEN;
    logic [7:0] WEN;
    logic [3:0] A;
    logic [7:0] D;
    logic [7:0] Q;
    logic       Q_VALID;
    logic       BUSY;
    logic       CEN_SRAM;
    logic       GWEN_SRAM;
    logic [7:0] WEN_SRAM;
    logic [7:0] D_SRAM;
    logic [3:0] A_SRAM;
    logic [7:0] Q_SRAM;
    logic       CLK_SRAM;

    int checkCount = 0;
    int errorCount = 0;
    int writeCount = 0;
    logic [7:0] mem [16];

`ifdef GF_SRAM_PORT_CTRL_CLEAR_EN
    localparam logic [7:0] EXP_ADDR7 = 8'h00;
    localparam logic [7:0] EXP_ADDR3_AFTER_RECONF = 8'h00;
`else
    localparam logic [7:0] EXP_ADDR7 = 8'h37;
    localparam logic [7:0] EXP_ADDR3_AFTER_RECONF = 8'hA5;
`endif

    gf_sram_port_ctrl #(.WIDTH(8), .ADDR_BITS(4)) dut (
        .UserCLK(UserCLK), .RST(RST), .CONFIGURED_top(CONFIGURED_top),
        .CEN(CEN), .GWEN(GWEN), .WEN(WEN), .A(A), .D(D),
        .Q(Q), .Q_VALID(Q_VALID), .BUSY(BUSY),
        .CEN_SRAM(CEN_SRAM), .GWEN_SRAM(GWEN_SRAM), .WEN_SRAM(WEN_SRAM),
        .D_SRAM(D_SRAM), .A_SRAM(A_SRAM), .Q_SRAM(Q_SRAM), .CLK_SRAM(CLK_SRAM)
    );

    initial begin
        UserCLK = 1'b0;
        forever #5 UserCLK = ~UserCLK;
    end

    // Macro model: registered read, active-low per-bit write mask; preloaded so untouched contents are recognisable.
    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'h30 + 8'(i);
        Q_SRAM = 8'h00;
    end

    always @(posedge UserCLK) begin
        if (!CEN_SRAM && !GWEN_SRAM) begin
            mem[A_SRAM] <= (mem[A_SRAM] & WEN_SRAM) | (D_SRAM & ~WEN_SRAM);
            writeCount  <= writeCount + 1;
        end else if (!CEN_SRAM) begin
            Q_SRAM <= mem[A_SRAM];
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) else begin
            errorCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge UserCLK);
        #1;
    endtask

    task automatic applyStimulus(input logic cen, input logic gwen, input logic [7:0] wen,
                                 input logic [3:0] a, input logic [7:0] d);
        CEN  = cen;
        GWEN = gwen;
        WEN  = wen;
        A    = a;
        D    = d;
        #1;
    endtask

    task automatic applyIdle();
        applyStimulus(1'b1, 1'b1, 8'hFF, 4'd0, 8'h00);
    endtask

    initial begin
        RST = 1'b1;
        CONFIGURED_top = 1'b0;
        applyIdle();
        stepCycle();
        stepCycle();

        // Read attempt while held in reset must not reach the macro.
        applyStimulus(1'b0, 1'b1, 8'hFF, 4'd5, 8'h3C);
        checkOutput("rst_q", Q, 8'h00);
        checkOutput("rst_qvalid", Q_VALID, 1'b0);
        checkOutput("rst_busy", BUSY, 1'b1);
        checkOutput("rst_cen_sram", CEN_SRAM, 1'b1);
        checkOutput("rst_gwen_sram", GWEN_SRAM, 1'b1);
        checkOutput("rst_wen_sram", WEN_SRAM, 8'hFF);
        checkOutput("rst_a_sram", A_SRAM, 4'h0);
        checkOutput("rst_d_sram", D_SRAM, 8'h00);
        checkOutput("rst_clk_hi", CLK_SRAM, UserCLK);
        @(negedge UserCLK);
        #1;
        checkOutput("rst_clk_lo", CLK_SRAM, UserCLK);

        stepCycle();
        RST = 1'b0;
        applyIdle();
        stepCycle();
        checkOutput("unconf_busy", BUSY, 1'b1);
        checkOutput("unconf_q", Q, 8'h00);

        CONFIGURED_top = 1'b1;
        applyStimulus(1'b0, 1'b1, 8'hFF, 4'd9, 8'h00);
        checkOutput("cfg_edge_cen_sram", CEN_SRAM, 1'b1);
        checkOutput("cfg_edge_busy", BUSY, 1'b1);

`ifdef GF_SRAM_PORT_CTRL_CLEAR_EN
        for (int i = 0; i < 16; i++) begin
            stepCycle();
            applyStimulus(1'b0, 1'b1, 8'hFF, 4'd5, 8'h00);
            checkOutput("clr_a_sram", A_SRAM, i);
            checkOutput("clr_cen_sram", CEN_SRAM, 1'b0);
            checkOutput("clr_gwen_sram", GWEN_SRAM, 1'b0);
            checkOutput("clr_wen_sram", WEN_SRAM, 8'h00);
            checkOutput("clr_d_sram", D_SRAM, 8'h00);
            checkOutput("clr_busy", BUSY, 1'b1);
            checkOutput("clr_qvalid", Q_VALID, 1'b0);
        end
        stepCycle();
        applyIdle();
        checkOutput("clr_done_busy", BUSY, 1'b0);
        checkOutput("clr_write_count", writeCount, 16);
        checkOutput("clr_done_qvalid", Q_VALID, 1'b0);
`else
        stepCycle();
        applyIdle();
        checkOutput("noclr_busy", BUSY, 1'b0);
        checkOutput("noclr_write_count", writeCount, 0);
        checkOutput("noclr_qvalid", Q_VALID, 1'b0);
`endif

        applyStimulus(1'b0, 1'b1, 8'hFF, 4'd7, 8'h00);
        checkOutput("rd7_a_sram", A_SRAM, 4'd7);
        checkOutput("rd7_cen_sram", CEN_SRAM, 1'b0);
        checkOutput("rd7_gwen_sram", GWEN_SRAM, 1'b1);
        checkOutput("rd7_qvalid_same", Q_VALID, 1'b0);
        stepCycle();
        applyIdle();
        checkOutput("rd7_qvalid", Q_VALID, 1'b1);
        checkOutput("rd7_q", Q, EXP_ADDR7);
        stepCycle();
        checkOutput("rd7_qvalid_drop", Q_VALID, 1'b0);
        checkOutput("rd7_q_hold", Q, EXP_ADDR7);

        applyStimulus(1'b0, 1'b0, 8'h00, 4'd3, 8'hA5);
        checkOutput("wr3_d_sram", D_SRAM, 8'hA5);
        checkOutput("wr3_gwen_sram", GWEN_SRAM, 1'b0);
        checkOutput("wr3_wen_sram", WEN_SRAM, 8'h00);
        checkOutput("wr3_q_unchanged", Q, EXP_ADDR7);
        stepCycle();
        applyStimulus(1'b0, 1'b1, 8'hFF, 4'd3, 8'h00);
        checkOutput("rd3_qvalid_same", Q_VALID, 1'b0);
        stepCycle();
        applyIdle();
        checkOutput("rd3_qvalid", Q_VALID, 1'b1);
        checkOutput("rd3_q", Q, 8'hA5);
        for (int k = 0; k < 5; k++) begin
            stepCycle();
            if (k == 2) applyStimulus(1'b0, 1'b0, 8'h00, 4'd4, 8'h77);
            else applyIdle();
            checkOutput("rd3_hold_q", Q, 8'hA5);
            checkOutput("rd3_hold_qvalid", Q_VALID, 1'b0);
        end

        // Masked write: WEN bits low are written, so only the low nibble is protected here.
        stepCycle();
        applyStimulus(1'b0, 1'b0, 8'h00, 4'd2, 8'hFF);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 8'h0F, 4'd2, 8'h00);
        stepCycle();
        applyStimulus(1'b0, 1'b1, 8'hFF, 4'd3, 8'h00);
        stepCycle();
        applyStimulus(1'b0, 1'b1, 8'hFF, 4'd2, 8'h00);
        checkOutput("b2b_first_qvalid", Q_VALID, 1'b1);
        checkOutput("b2b_first_q", Q, 8'hA5);
        stepCycle();
        applyIdle();
        checkOutput("b2b_second_qvalid", Q_VALID, 1'b1);
        checkOutput("mask_q", Q, 8'h0F);
        stepCycle();
        checkOutput("b2b_end_qvalid", Q_VALID, 1'b0);
        checkOutput("mask_q_hold", Q, 8'h0F);

`ifdef GF_SRAM_PORT_CTRL_CLEAR_EN
        CONFIGURED_top = 1'b0;
        #1;
        stepCycle();
        CONFIGURED_top = 1'b1;
        #1;
        for (int i = 0; i < 10; i++) begin
            stepCycle();
            checkOutput("abort_a_sram", A_SRAM, i);
        end
        CONFIGURED_top = 1'b0;
        #1;
        checkOutput("abort_cen_sram", CEN_SRAM, 1'b1);
        checkOutput("abort_a_gated", A_SRAM, 4'd0);
        stepCycle();
        CONFIGURED_top = 1'b1;
        #1;
        checkOutput("abort_unconf_cen", CEN_SRAM, 1'b1);
        checkOutput("abort_unconf_busy", BUSY, 1'b1);
        for (int i = 0; i < 16; i++) begin
            stepCycle();
            checkOutput("resweep_a_sram", A_SRAM, i);
            checkOutput("resweep_busy", BUSY, 1'b1);
        end
        stepCycle();
        checkOutput("resweep_done_busy", BUSY, 1'b0);
`else
        applyStimulus(1'b0, 1'b1, 8'hFF, 4'd3, 8'h00);
        CONFIGURED_top = 1'b0;
        #1;
        checkOutput("unconf_drop_cen_sram", CEN_SRAM, 1'b1);
        checkOutput("unconf_drop_busy", BUSY, 1'b1);
        stepCycle();
        applyIdle();
        checkOutput("unconf_drop_qvalid", Q_VALID, 1'b0);
        CONFIGURED_top = 1'b1;
        #1;
        checkOutput("reconf_busy", BUSY, 1'b1);
        stepCycle();
        checkOutput("reconf_ready_busy", BUSY, 1'b0);
`endif

        applyStimulus(1'b0, 1'b1, 8'hFF, 4'd3, 8'h00);
        stepCycle();
        applyIdle();
        checkOutput("reconf_rd3_qvalid", Q_VALID, 1'b1);
        checkOutput("reconf_rd3_q", Q, EXP_ADDR3_AFTER_RECONF);

        stepCycle();
        RST = 1'b1;
        applyStimulus(1'b0, 1'b1, 8'hFF, 4'd2, 8'h00);
        checkOutput("rstrd_cen_sram", CEN_SRAM, 1'b1);
        checkOutput("rstrd_busy", BUSY, 1'b1);
        stepCycle();
        RST = 1'b0;
        applyIdle();
        checkOutput("rstrd_q", Q, 8'h00);
        checkOutput("rstrd_qvalid", Q_VALID, 1'b0);
        checkOutput("rstrd_busy_after", BUSY, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
